sequence_generator_fsm: RTL

SEQUENCE_GENERATOR_FSM -- requirements
Module: sequence_generator_fsm

---
 rtl/sequence_generator_fsm.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sequence_generator_fsm.sv
// Serial pattern generator: sends a latched pattern MSB-first, repeated
// Repeat+1 times with Gap idle cycles between frames, then pulses Done.
module sequence_generator_fsm #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [MAX_LEN-1:0] Pattern,
    input  logic [LEN_W-1:0]   Length,
    input  logic [3:0]         Repeat,
    input  logic [3:0]         Gap,
    output logic               Y,
    output logic               Valid,
    output logic               Busy,
    output logic               Done,
    output logic [1:0]         dbg_state
);

    // Handshake: Start is a level request, taken only on an edge where the FSM
    // is IDLE and Length!=0; Valid marks each cycle on which Y carries data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [3:0]         rep_q, rep_d;
    logic [3:0]         gap_q, gap_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               y_d, valid_d, busy_d, done_d;
    logic [LEN_W-1:0]   len_clamp;

    function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
        logic [MAX_LEN-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_clamp = (Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : Length;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        y_d       = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && (Length != '0)) begin
                    pat_d   = Pattern;
                    len_d   = len_clamp;
                    rep_d   = Repeat;
                    gap_d   = Gap;
                    idx_d   = len_clamp - LEN_W'(1);
                    y_d     = bit_at(Pattern, len_clamp - LEN_W'(1));
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (idx_q != '0) begin
                    idx_d   = idx_q - LEN_W'(1);
                    y_d     = bit_at(pat_q, idx_q - LEN_W'(1));
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != 4'd0) begin
                    // idx is rewound here so GAP can resume straight at the MSB
                    rep_d  = rep_q - 4'd1;
                    idx_d  = len_q - LEN_W'(1);
                    busy_d = 1'b1;
                    if (gap_q == 4'd0) begin
                        y_d     = bit_at(pat_q, len_q - LEN_W'(1));
                        valid_d = 1'b1;
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = GAP;
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == 4'd1) begin
                    y_d     = bit_at(pat_q, idx_q);
                    valid_d = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            Y         <= 1'b0;
            Valid     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            Y         <= y_d;
            Valid     <= valid_d;
            Busy      <= busy_d;
            Done      <= done_d;
        end
    end

endmodule
